// File: rtl/cnn_fp16_pkg.sv
// Shared fp16 types and constants for the CNN feature-map pipeline.
package cnn_fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_NEG_INF  = 16'hFC00;
  localparam fp16_t FP16_POS_ZERO = 16'h0000;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp16_max_comparator.sv
// Combinational fp16 max: sign-magnitude order, +0 == -0, ties return operand a.
module fp16_max_comparator
  import cnn_fp16_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t max_val
);

  logic w_a_zero;
  logic w_b_zero;
  logic w_b_gt;

  assign w_a_zero = (a[14:0] == 15'd0);
  assign w_b_zero = (b[14:0] == 15'd0);

  always_comb begin
    w_b_gt = 1'b0;
    if (w_a_zero && w_b_zero) begin
      w_b_gt = 1'b0;
    end else if (a[15] != b[15]) begin
      w_b_gt = a[15];
    end else if (!a[15]) begin
      w_b_gt = (b[14:0] > a[14:0]);
    end else begin
      // Both negative: smaller magnitude is larger.
      w_b_gt = (b[14:0] < a[14:0]);
    end
  end

  assign max_val = w_b_gt ? b : a;

endmodule

// File: rtl/maxpool_stream.sv
// Streaming KxK / stride-K fp16 max-pool with a line buffer of per-window partial maxima.
module maxpool_stream
  import cnn_fp16_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24,
  parameter int unsigned POOL_K = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned GN = IMG_W / POOL_K;
  localparam int unsigned WN = IMG_H / POOL_K;
  localparam int unsigned KW = cnt_w(POOL_K);
  localparam int unsigned GW = cnt_w(GN);
  localparam int unsigned RW = cnt_w(WN);

  localparam logic [KW-1:0] K_MAX = KW'(POOL_K - 1);
  localparam logic [GW-1:0] G_MAX = GW'(GN - 1);
  localparam logic [RW-1:0] R_MAX = RW'(WN - 1);

  if (DATA_W != 16 || POOL_K < 2 || POOL_K > 4 ||
      (IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0) begin : g_param_check
    $fatal(1, "maxpool_stream: illegal parameter combination");
  end

  logic [KW-1:0]     r_kc;
  logic [KW-1:0]     r_kr;
  logic [GW-1:0]     r_g;
  logic [RW-1:0]     r_wr;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_linebuf [GN];

  logic              w_accept;
  logic              w_kc_last;
  logic              w_g_last;
  logic              w_kr_last;
  logic              w_wr_last;
  logic              w_win_done;
  logic [DATA_W-1:0] w_base;
  logic [DATA_W-1:0] w_partial;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_kc_last  = (r_kc == K_MAX);
  assign w_g_last   = (r_g == G_MAX);
  assign w_kr_last  = (r_kr == K_MAX);
  assign w_wr_last  = (r_wr == R_MAX);
  assign w_win_done = w_kc_last && w_kr_last;

  // First pixel of a window row starts from the line buffer, except the window's top row.
  always_comb begin
    w_base = FP16_NEG_INF;
    if (r_kc != '0) begin
      w_base = r_acc;
    end else if (r_kr != '0) begin
      w_base = r_linebuf[r_g];
    end
  end

  fp16_max_comparator u_max (
    .a      (in_data),
    .b      (w_base),
    .max_val(w_partial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kc  <= '0;
      r_g   <= '0;
      r_kr  <= '0;
      r_wr  <= '0;
      r_acc <= FP16_NEG_INF;
    end else if (clear) begin
      r_kc  <= '0;
      r_g   <= '0;
      r_kr  <= '0;
      r_wr  <= '0;
      r_acc <= FP16_NEG_INF;
    end else if (w_accept) begin
      r_acc <= w_partial;
      if (!w_kc_last) begin
        r_kc <= r_kc + 1'b1;
      end else begin
        r_kc <= '0;
        if (!w_g_last) begin
          r_g <= r_g + 1'b1;
        end else begin
          r_g <= '0;
          if (!w_kr_last) begin
            r_kr <= r_kr + 1'b1;
          end else begin
            r_kr <= '0;
            r_wr <= w_wr_last ? '0 : r_wr + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_kc_last && !w_kr_last) begin
      r_linebuf[r_g] <= w_partial;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= FP16_POS_ZERO;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_data  <= FP16_POS_ZERO;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_win_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_partial;
      r_out_last  <= w_g_last && w_wr_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench: 4x4/K=2 and 6x6/K=3 instances, directed frames plus random streams.
module tb_maxpool_stream;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       clear;
  logic [1:0][15:0] in_data;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][15:0] out_data;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0]       out_last;

  always #5 clk = ~clk;

  maxpool_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .POOL_K(2)) u_dut_k2 (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear[0]),
    .in_data  (in_data[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .out_data (out_data[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_last (out_last[0])
  );

  maxpool_stream #(.DATA_W(16), .IMG_W(6), .IMG_H(6), .POOL_K(3)) u_dut_k3 (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear[1]),
    .in_data  (in_data[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .out_data (out_data[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_last (out_last[1])
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  int          pcount[2];
  logic [15:0] frame[2][36];
  bit          use_model[2];
  int          ready_mode[2];
  bit          lat_chk = 1'b0;
  logic [15:0] stim[36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int img_w(input int sel);
    return (sel == 0) ? 4 : 6;
  endfunction

  function automatic int pool_k(input int sel);
    return (sel == 0) ? 2 : 3;
  endfunction

  function automatic logic [15:0] int_to_fp16(input int n);
    int e = 0;
    int mant;
    while ((n >> (e + 1)) != 0) e++;
    mant = (n << (10 - e)) & 32'h3FF;
    return {1'b0, 5'(e + 15), 10'(mant)};
  endfunction

  function automatic real fp16_real(input logic [15:0] b);
    int  e = int'(b[14:10]);
    real r;
    if (e == 31) begin
      r = 1.0e300;
    end else if (e == 0) begin
      r = real'(b[9:0]) / 16777216.0;
    end else begin
      r = real'(1024 + int'(b[9:0]));
      if (e >= 25) for (int i = 0; i < e - 25; i++) r = r * 2.0;
      else for (int i = 0; i < 25 - e; i++) r = r / 2.0;
    end
    return b[15] ? -r : r;
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] v = 16'($urandom);
    case ($urandom % 16)
      0: v = ($urandom % 2) ? 16'h8000 : 16'h0000;
      1: v = ($urandom % 2) ? 16'hFC00 : 16'h7C00;
      2: v = ($urandom % 2) ? 16'h3C00 : 16'hBC00;
      default: if (v[14:10] == 5'd31) v[9:0] = '0;
    endcase
    return v;
  endfunction

  task automatic push_exp(input int sel, input logic last, input logic [15:0] v);
    if (sel == 0) q0.push_back({last, v});
    else q1.push_back({last, v});
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  // Window max taken over the window's pixels in arrival order; an equal later pixel wins.
  task automatic model_accept(input int sel, input logic [15:0] p, output bit done);
    int w = img_w(sel);
    int k = pool_k(sel);
    int r = pcount[sel] / w;
    int c = pcount[sel] % w;
    real best;
    real v;
    logic [15:0] bv;
    frame[sel][pcount[sel]] = p;
    pcount[sel]++;
    done = (c % k == k - 1) && (r % k == k - 1);
    if (done) begin
      best = -2.0e300;
      bv = 16'hFC00;
      for (int rr = r - k + 1; rr <= r; rr++) begin
        for (int cc = c - k + 1; cc <= c; cc++) begin
          v = fp16_real(frame[sel][rr * w + cc]);
          if (v >= best) begin
            best = v;
            bv = frame[sel][rr * w + cc];
          end
        end
      end
      if (use_model[sel]) push_exp(sel, (r == w - 1) && (c == w - 1), bv);
    end
    if (pcount[sel] == w * w) pcount[sel] = 0;
  endtask

  task automatic send(input int sel, input logic [15:0] p, input bit gaps);
    bit ok = 1'b0;
    bit rdy;
    bit done;
    if (gaps) while ($urandom % 3 == 0) begin @(posedge clk); #1; end
    in_valid[sel] = 1'b1;
    in_data[sel] = p;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = in_ready[sel];
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid[sel] = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout dut%0d: pixel %h never accepted", sel, p);
    end else begin
      model_accept(sel, p, done);
      if (lat_chk && done) begin
        @(negedge clk);
        check("latency_valid", 32'(out_valid[sel]), 32'd1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_stim(input int sel, input int n, input bit gaps);
    for (int i = 0; i < n; i++) send(sel, stim[i], gaps);
  endtask

  task automatic wait_drain(input int sel);
    for (int t = 0; t < 300; t++) begin
      if (qsize(sel) == 0 && !out_valid[sel]) break;
      @(posedge clk);
      #1;
    end
    check($sformatf("drain_dut%0d", sel), 32'(qsize(sel)), 32'd0);
  endtask

  task automatic do_clear(input int sel);
    clear[sel] = 1'b1;
    @(posedge clk);
    #1;
    clear[sel] = 1'b0;
    pcount[sel] = 0;
  endtask

  task automatic push_frame1(input int sel);
    push_exp(sel, 1'b0, 16'h4600);
    push_exp(sel, 1'b0, 16'h4800);
    push_exp(sel, 1'b0, 16'h4B00);
    push_exp(sel, 1'b1, 16'h4C00);
  endtask

  task automatic load_ramp(input bit neg);
    for (int i = 0; i < 16; i++) stim[i] = int_to_fp16(i + 1) | (neg ? 16'h8000 : 16'h0000);
  endtask

  // Monitor: every completed output handshake pops one expected {last, data}.
  always @(negedge clk) begin
    logic [16:0] e;
    bit have;
    for (int s = 0; s < 2; s++) begin
      if (!rst && out_valid[s] && out_ready[s]) begin
        have = (qsize(s) > 0);
        if (have) e = (s == 0) ? q0.pop_front() : q1.pop_front();
        if (!have) begin
          n_checks++;
          $display("FAIL unexpected_output dut%0d: got %h, nothing expected", s, out_data[s]);
        end else begin
          check($sformatf("out_dut%0d", s), 32'({out_last[s], out_data[s]}), 32'(e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        case (ready_mode[s])
          0: out_ready[s] = 1'b1;
          1: out_ready[s] = 1'b0;
          default: out_ready[s] = ($urandom % 3 != 0);
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear = '0;
    in_valid = '0;
    in_data = '0;
    out_ready = '1;
    for (int s = 0; s < 2; s++) begin
      pcount[s] = 0;
      use_model[s] = 1'b1;
      ready_mode[s] = 0;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_out_valid%0d", s), 32'(out_valid[s]), 32'd0);
      check($sformatf("rst_out_data%0d", s), 32'(out_data[s]), 32'h0000);
      check($sformatf("rst_out_last%0d", s), 32'(out_last[s]), 32'd0);
      check($sformatf("rst_in_ready%0d", s), 32'(in_ready[s]), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ascending ramp, with one-cycle latency checked on each window.
    use_model[0] = 1'b0;
    load_ramp(1'b0);
    push_frame1(0);
    lat_chk = 1'b1;
    send_stim(0, 16, 1'b0);
    lat_chk = 1'b0;
    wait_drain(0);

    // All-negative frame: max must come from -inf init, never zero.
    load_ramp(1'b1);
    push_exp(0, 1'b0, 16'hBC00);
    push_exp(0, 1'b0, 16'hC200);
    push_exp(0, 1'b0, 16'hC880);
    push_exp(0, 1'b1, 16'hC980);
    send_stim(0, 16, 1'b0);
    wait_drain(0);

    // Backpressure: first output held for 5 cycles with in_ready low.
    load_ramp(1'b0);
    push_frame1(0);
    ready_mode[0] = 1;
    fork
      send_stim(0, 16, 1'b0);
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (out_valid[0]) break;
        end
        for (int i = 0; i < 5; i++) begin
          check("stall_out_valid", 32'(out_valid[0]), 32'd1);
          check("stall_in_ready", 32'(in_ready[0]), 32'd0);
          check("stall_out_data", 32'(out_data[0]), 32'h4600);
          @(negedge clk);
        end
        ready_mode[0] = 0;
      end
    join
    wait_drain(0);
    use_model[0] = 1'b1;

    // Signed zeros in window 0, +inf in window 1.
    load_ramp(1'b0);
    stim[0] = 16'h0000;
    stim[1] = 16'h8000;
    stim[4] = 16'h8000;
    stim[5] = 16'h8000;
    stim[7] = 16'h7C00;
    send_stim(0, 16, 1'b0);
    wait_drain(0);

    // Clear after 6 pixels, then a fresh frame.
    for (int i = 0; i < 6; i++) stim[i] = rand_fp16();
    send_stim(0, 6, 1'b0);
    wait_drain(0);
    do_clear(0);
    use_model[0] = 1'b0;
    load_ramp(1'b0);
    push_frame1(0);
    send_stim(0, 16, 1'b0);
    wait_drain(0);
    use_model[0] = 1'b1;

    // Asynchronous reset while an output is pending.
    ready_mode[0] = 1;
    for (int i = 0; i < 6; i++) stim[i] = rand_fp16();
    send_stim(0, 6, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("async_rst_out_data", 32'(out_data[0]), 32'h0000);
    q0.delete();
    pcount[0] = 0;
    pcount[1] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode[0] = 0;
    @(posedge clk);
    #1;

    // Random streams with input gaps and output backpressure.
    ready_mode[0] = 2;
    ready_mode[1] = 2;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) stim[i] = rand_fp16();
      send_stim(0, 16, 1'b1);
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 36; i++) stim[i] = rand_fp16();
      send_stim(1, 36, 1'b1);
    end
    ready_mode[0] = 0;
    ready_mode[1] = 0;
    wait_drain(0);
    wait_drain(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
